// File: rtl/traffic_input_cond.sv
// Input conditioning for the traffic-light controller: synchronises and debounces the
// sensor and walk button, and latches walk requests until acknowledged. Optional macro: PRESS_CNT_EN.
module traffic_input_cond #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 500000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_raw,
    input  logic       button_walk_raw,
    input  logic       walk_ack,
    output logic       sensor,
    output logic       walk_req,
    output logic       walk_press
`ifdef PRESS_CNT_EN
    ,
    output logic [7:0] press_count
`endif
);

    localparam int unsigned N_IN     = 2;
    localparam int unsigned IDX_SENS = 0;
    localparam int unsigned IDX_BTN  = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic {ST_STABLE, ST_CHECK} deb_state_e;

    logic [SYNC_STAGES-1:0] sync_q  [N_IN];
    logic [SYNC_STAGES-1:0] sync_d  [N_IN];
    deb_state_e             state_q [N_IN];
    deb_state_e             state_d [N_IN];
    logic [CNT_W-1:0]       cnt_q   [N_IN];
    logic [CNT_W-1:0]       cnt_d   [N_IN];
    logic [N_IN-1:0]        deb_q, deb_d;
    logic [N_IN-1:0]        raw_c, s_c;
    logic                   d_btn_q, d_btn_d;
    logic                   walk_press_q, walk_press_d;
    logic                   walk_req_q, walk_req_d;
    logic                   press_c;

    assign raw_c = {button_walk_raw, sensor_raw};

    // Synchroniser chains; s_c is the last stage of each.
    always_comb begin
        for (int i = 0; i < int'(N_IN); i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw_c[i]};
            s_c[i]    = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Debounce FSM per input: a changed level must persist DEB_CYCLES cycles to be accepted.
    always_comb begin
        for (int i = 0; i < int'(N_IN); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            deb_d[i]   = deb_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    if (s_c[i] != deb_q[i]) begin
                        state_d[i] = ST_CHECK;
                        cnt_d[i]   = CNT_W'(1);
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end
                ST_CHECK: begin
                    if (s_c[i] == deb_q[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] >= CNT_LAST) begin
                        deb_d[i]   = s_c[i];
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Rising-edge detect on the debounced button; a press beats a same-cycle acknowledge.
    always_comb begin
        press_c      = deb_q[IDX_BTN] & ~d_btn_q;
        d_btn_d      = deb_q[IDX_BTN];
        walk_press_d = press_c;
        walk_req_d   = walk_req_q;
        if (press_c) begin
            walk_req_d = 1'b1;
        end else if (walk_ack) begin
            walk_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(N_IN); i++) begin
                sync_q[i]  <= '0;
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
            deb_q        <= '0;
            d_btn_q      <= 1'b0;
            walk_press_q <= 1'b0;
            walk_req_q   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N_IN); i++) begin
                sync_q[i]  <= sync_d[i];
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            deb_q        <= deb_d;
            d_btn_q      <= d_btn_d;
            walk_press_q <= walk_press_d;
            walk_req_q   <= walk_req_d;
        end
    end

    assign sensor     = deb_q[IDX_SENS];
    assign walk_req   = walk_req_q;
    assign walk_press = walk_press_q;

`ifdef PRESS_CNT_EN
    logic [7:0] press_cnt_q, press_cnt_d;

    // Saturating count of accepted presses.
    always_comb begin
        press_cnt_d = press_cnt_q;
        if (press_c && (press_cnt_q != 8'hFF)) begin
            press_cnt_d = press_cnt_q + 8'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_cnt_q <= '0;
        end else begin
            press_cnt_q <= press_cnt_d;
        end
    end

    assign press_count = press_cnt_q;
`endif

endmodule

// File: doc/traffic_input_cond.md
Name: traffic_input_cond

Overview:
Input-conditioning stage that sits directly upstream of the traffic-light controller FSM. It takes the raw asynchronous pins `sensor` and `button_walk` and synchronises and debounces each one. It then presents the controller with a clean side-street sensor level and a latched pedestrian walk request. The walk request is held until the controller acknowledges it, so a short press is never lost while the FSM is elsewhere in its cycle.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchroniser chain (minimum 2).
- DEB_CYCLES, 500000, consecutive clk cycles of a changed synchronised level required before the debounced output follows (5 ms at 100 MHz; the bench uses 4).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- sensor_raw, input, 1, raw side-street vehicle sensor pin (asynchronous).
- button_walk_raw, input, 1, raw pedestrian push-button pin (asynchronous, active-high).
- walk_ack, input, 1, one-cycle pulse from the controller when it enters the walk state; clears the request.
- sensor, output, 1, debounced, synchronised sensor level.
- walk_req, output, 1, latched walk request; level-held until acknowledged.
- walk_press, output, 1, one-cycle pulse for each accepted (debounced) button press.

Behaviour:
- **Reset** (reset=0, asynchronous):
  - all synchroniser flops, debounce counters and debounced levels go to 0;
  - sensor=0, walk_req=0, walk_press=0;
  - a reset asserted mid-debounce or while a request is pending discards everything;
  - after release, the outputs first change on the rising edge following the conditions below.
- **Synchroniser:** each raw input passes through SYNC_STAGES flops; `s_x` is the last stage.
- **Debounce:** one independent FSM per input, with a stable level `d_x` and a counter `cnt_x`.
  - State STABLE: `s_x == d_x`; cnt_x held at 0.
    - `s_x != d_x` → go to CHECK with cnt_x=1.
  - State CHECK:
    - `s_x == d_x` (glitch) → return to STABLE, cnt_x=0;
    - otherwise cnt_x increments;
    - when cnt_x == DEB_CYCLES-1 and `s_x` still differs: `d_x <= s_x`, cnt_x=0, go to STABLE.
  - Net latency from a clean raw edge to a `d_x` change is SYNC_STAGES+DEB_CYCLES clocks.
  - Any pulse shorter than DEB_CYCLES synchronised cycles produces no output change.
- **Outputs from debounce:**
  - sensor = d_sensor, driven directly from the register;
  - button edge detect: press = d_btn & ~d_btn_q, where d_btn_q is d_btn delayed one cycle;
  - walk_press is registered and asserts one clock after d_btn rises, for exactly one cycle;
  - release edges are ignored.
- **Walk request latch** (registered; evaluated with walk_press timing):
  - press=1 → walk_req=1 on the same edge that walk_press asserts;
  - walk_ack=1 and no press → walk_req=0 on the next edge;
  - press and walk_ack in the same cycle → set wins, walk_req stays or becomes 1 (the new press is served next cycle);
  - press while walk_req is already 1 → walk_req stays 1 (no queueing), walk_press still pulses;
  - walk_ack while walk_req=0 → no effect.
- **Holding the button:** a held button produces a single press; a new request requires release (debounced) and a re-press.
- **Sensor path:** sensor is a plain level; no latching, no acknowledge.

Optional Feature:
- Macro: PRESS_CNT_EN.
- Defined:
  - adds output port press_count[7:0];
  - increments by 1 on every walk_press pulse;
  - saturates at 255 (no wrap);
  - cleared only by reset;
  - never affected by walk_ack.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan (SYNC_STAGES=2, DEB_CYCLES=4):
- Reset behaviour: hold reset=0 with both raw inputs=1 → sensor=0, walk_req=0, walk_press=0 throughout. Release reset with inputs steady at 1 → sensor rises on the 6th rising edge.
- Glitch rejection: button_walk_raw=1 for 3 clocks, then 0 → walk_press never pulses, walk_req stays 0, press_count stays 0.
- Clean press: button_walk_raw=1 held 20 clocks → walk_press high for exactly 1 cycle, 7 edges after the raw rise, and walk_req=1 from that same edge. A later walk_ack pulse → walk_req=0 one edge later.
- Simultaneous events: arrange for walk_ack to coincide with the press cycle of a second press → walk_req remains 1. Next lone walk_ack → walk_req=0.
- Held button and press counter: hold button 100 clocks → exactly one walk_press. Then 300 clean release/press pairs → press_count=255 (saturated).
- Reset mid-operation: assert reset during CHECK (cnt=2) and with walk_req=1 → all outputs are 0 immediately. After release with raw inputs at 0 → outputs remain 0.
